// File: rtl/ibex_rf_wb_merge.sv
// ============================================================================
// Module      : ibex_rf_wb_merge
// Description : Write-back merge stage ahead of the register-file write port.
//               Merges the single-cycle execute write-back with the
//               variable-latency load write-back into one registered write
//               stream. Loads that lose arbitration wait in a small in-order
//               FIFO, and a per-register pending mask is exported so decode
//               can stall on hazards against queued loads.
//
// Parameters  : DataWidth  - write data width
//               NumRegs    - number of architectural registers
//               FifoDepth  - load holding entries (1..4)
//
// Ports       : clk_i, rst_i              clock, synchronous active-high reset
//               ex_we_i/_waddr_i/_wdata_i execute write (always accepted)
//               lsu_valid_i/lsu_ready_o   load write handshake
//               lsu_waddr_i/lsu_wdata_i   load write address / data
//               rf_we_o/_waddr_o/_wdata_o registered register-file write
//               pending_o                 registers targeted by queued loads
//               stall_cnt_o               load back-pressure cycle counter
//
// Build option: IBEX_RF_WB_STATS_EN - when defined, stall_cnt_o is a 16-bit
//               saturating count of cycles with lsu_valid_i=1 and
//               lsu_ready_o=0; otherwise stall_cnt_o is tied to zero.
//
// Revision    : 1.0 - initial release
// ============================================================================

`default_nettype none

module ibex_rf_wb_merge #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumRegs   = 32,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,

    input  logic                         ex_we_i,
    input  logic [$clog2(NumRegs)-1:0]   ex_waddr_i,
    input  logic [DataWidth-1:0]         ex_wdata_i,

    input  logic                         lsu_valid_i,
    output logic                         lsu_ready_o,
    input  logic [$clog2(NumRegs)-1:0]   lsu_waddr_i,
    input  logic [DataWidth-1:0]         lsu_wdata_i,

    output logic                         rf_we_o,
    output logic [$clog2(NumRegs)-1:0]   rf_waddr_o,
    output logic [DataWidth-1:0]         rf_wdata_o,

    output logic [NumRegs-1:0]           pending_o,
    output logic [15:0]                  stall_cnt_o
);

    localparam int unsigned ADDR_WIDTH = $clog2(NumRegs);
    localparam int unsigned CNT_W      = $clog2(FifoDepth + 1);

    // ------------------------------------------------------------------------
    // FIFO storage. Entries are kept compacted toward index 0, so the head is
    // always entry 0 and r_valid is a thermometer code.
    // ------------------------------------------------------------------------
    logic [FifoDepth-1:0]  r_valid;
    logic [ADDR_WIDTH-1:0] r_addr [FifoDepth];
    logic [DataWidth-1:0]  r_data [FifoDepth];

    logic [FifoDepth-1:0]  w_nxt_valid;
    logic [ADDR_WIDTH-1:0] w_nxt_addr [FifoDepth];
    logic [DataWidth-1:0]  w_nxt_data [FifoDepth];

    logic [CNT_W-1:0]      w_count;
    logic [FifoDepth-1:0]  w_live;
    logic [FifoDepth-1:0]  w_keep;

    logic                  w_ex_issue;
    logic                  w_pop;
    logic                  w_lsu_ready;
    logic                  w_lsu_fire;
    logic                  w_lsu_nz;
    logic                  w_lsu_dead;
    logic                  w_bypass;
    logic                  w_push;

    // Occupancy of the holding FIFO.
    always_comb begin
        w_count = '0;
        for (int i = 0; i < FifoDepth; i++) begin
            w_count = w_count + CNT_W'(r_valid[i]);
        end
    end

    // An execute write to x0 is discarded and never wins arbitration.
    assign w_ex_issue = ex_we_i && (ex_waddr_i != '0);

    // A queued load is older than any execute write issuing now, so an entry
    // targeting the same register is stale and is killed in this cycle.
    for (genvar g = 0; g < FifoDepth; g++) begin : g_live
        assign w_live[g] = r_valid[g] &&
                           !(w_ex_issue && (r_addr[g] == ex_waddr_i));
    end

    // Because storage is compacted and cancellation only happens while EX
    // issues, the head can pop exactly when EX is idle and the FIFO is
    // non-empty.
    assign w_pop       = !w_ex_issue && r_valid[0];

    assign w_lsu_ready = (w_count < CNT_W'(FifoDepth)) && !rst_i;
    assign w_lsu_fire  = lsu_valid_i && w_lsu_ready;
    assign w_lsu_nz    = (lsu_waddr_i != '0);

    // A load handed over in the same cycle as an execute write to the same
    // register is also older than that write; queueing it would later
    // overwrite the newer value, so it is dropped after the handshake.
    assign w_lsu_dead  = w_ex_issue && (lsu_waddr_i == ex_waddr_i);

    assign w_bypass    = w_lsu_fire && w_lsu_nz && !w_ex_issue && !r_valid[0];
    assign w_push      = w_lsu_fire && w_lsu_nz && !w_lsu_dead && !w_bypass;

    for (genvar g = 0; g < FifoDepth; g++) begin : g_keep
        if (g == 0) begin : g_head
            assign w_keep[g] = w_live[g] && !w_pop;
        end else begin : g_body
            assign w_keep[g] = w_live[g];
        end
    end

    // Next FIFO contents: surviving entries slide down in order, the accepted
    // load (if any) lands just behind them. Only constant indices are used;
    // the running rank selects the destination slot.
    always_comb begin
        logic [CNT_W-1:0] v_rank;
        v_rank      = '0;
        w_nxt_valid = '0;
        for (int j = 0; j < FifoDepth; j++) begin
            w_nxt_addr[j] = '0;
            w_nxt_data[j] = '0;
        end
        for (int i = 0; i < FifoDepth; i++) begin
            if (w_keep[i]) begin
                for (int j = 0; j < FifoDepth; j++) begin
                    if (v_rank == CNT_W'(j)) begin
                        w_nxt_valid[j] = 1'b1;
                        w_nxt_addr[j]  = r_addr[i];
                        w_nxt_data[j]  = r_data[i];
                    end
                end
                v_rank = v_rank + CNT_W'(1);
            end
        end
        if (w_push) begin
            for (int j = 0; j < FifoDepth; j++) begin
                if (v_rank == CNT_W'(j)) begin
                    w_nxt_valid[j] = 1'b1;
                    w_nxt_addr[j]  = lsu_waddr_i;
                    w_nxt_data[j]  = lsu_wdata_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            for (int j = 0; j < FifoDepth; j++) begin
                r_addr[j] <= '0;
                r_data[j] <= '0;
            end
        end else begin
            r_valid <= w_nxt_valid;
            for (int j = 0; j < FifoDepth; j++) begin
                r_addr[j] <= w_nxt_addr[j];
                r_data[j] <= w_nxt_data[j];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered write port: EX, then FIFO head, then bypassed load.
    // ------------------------------------------------------------------------
    logic                  r_rf_we;
    logic [ADDR_WIDTH-1:0] r_rf_waddr;
    logic [DataWidth-1:0]  r_rf_wdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else if (w_ex_issue) begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= ex_waddr_i;
            r_rf_wdata <= ex_wdata_i;
        end else if (w_pop) begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= r_addr[0];
            r_rf_wdata <= r_data[0];
        end else if (w_bypass) begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= lsu_waddr_i;
            r_rf_wdata <= lsu_wdata_i;
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

    assign rf_we_o     = r_rf_we;
    assign rf_waddr_o  = r_rf_waddr;
    assign rf_wdata_o  = r_rf_wdata;
    assign lsu_ready_o = w_lsu_ready;

    // Pending mask reflects only entries that survive this cycle's EX write;
    // an incoming push shows up from the next cycle on.
    always_comb begin
        pending_o = '0;
        for (int i = 0; i < FifoDepth; i++) begin
            if (w_live[i]) begin
                pending_o[r_addr[i]] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Back-pressure statistics.
    // ------------------------------------------------------------------------
`ifdef IBEX_RF_WB_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (lsu_valid_i && !w_lsu_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ibex_rf_wb_merge.sv
// ============================================================================
// Module      : tb_ibex_rf_wb_merge
// Description : Self-checking bench for ibex_rf_wb_merge. A table of
//               per-cycle vectors gives the inputs, the expected handshake
//               and pending mask before the clock edge, and the expected
//               register-file write after it. Reset and statistics corners
//               are hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================

`default_nettype none

module tb_ibex_rf_wb_merge;

    logic        clk;
    logic        rst;
    logic        ex_we;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_waddr;
    logic [31:0] lsu_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

`ifdef IBEX_RF_WB_STATS_EN
    localparam logic [15:0] c_exp_stall = 16'd3;
`else
    localparam logic [15:0] c_exp_stall = 16'd0;
`endif

    ibex_rf_wb_merge #(
        .DataWidth (32),
        .NumRegs   (32),
        .FifoDepth (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ex_we_i     (ex_we),
        .ex_waddr_i  (ex_waddr),
        .ex_wdata_i  (ex_wdata),
        .lsu_valid_i (lsu_valid),
        .lsu_ready_o (lsu_ready),
        .lsu_waddr_i (lsu_waddr),
        .lsu_wdata_i (lsu_wdata),
        .rf_we_o     (rf_we),
        .rf_waddr_o  (rf_waddr),
        .rf_wdata_o  (rf_wdata),
        .pending_o   (pending),
        .stall_cnt_o (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ex_we;
        logic [4:0]  ex_a;
        logic [31:0] ex_d;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        e_rdy;
        logic [31:0] e_pend;
        logic        e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    function automatic vec_t mk(logic xw, logic [4:0] xa, logic [31:0] xd,
                                logic lv, logic [4:0] la, logic [31:0] ld,
                                logic rdy, logic [31:0] pend,
                                logic we, logic [4:0] wa, logic [31:0] wd);
        vec_t v;
        v.ex_we = xw;  v.ex_a = xa;  v.ex_d = xd;
        v.lv    = lv;  v.la   = la;  v.ld   = ld;
        v.e_rdy = rdy; v.e_pend = pend;
        v.e_we  = we;  v.e_a  = wa;  v.e_d  = wd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0;
        lsu_valid = 1'b0; lsu_waddr = '0; lsu_wdata = '0;
    endtask

    // Called shortly after a rising edge: apply, check combinational
    // outputs mid-cycle, then check the registered write after the edge.
    task automatic step(input int idx);
        vec_t v;
        v = tbl[idx];
        ex_we = v.ex_we; ex_waddr = v.ex_a; ex_wdata = v.ex_d;
        lsu_valid = v.lv; lsu_waddr = v.la; lsu_wdata = v.ld;
        #1;
        check($sformatf("v%0d_ready", idx), 32'(lsu_ready), 32'(v.e_rdy));
        check($sformatf("v%0d_pending", idx), pending, v.e_pend);
        @(posedge clk);
        #1;
        check($sformatf("v%0d_rf_we", idx), 32'(rf_we), 32'(v.e_we));
        if (v.e_we) begin
            check($sformatf("v%0d_rf_waddr", idx), 32'(rf_waddr), 32'(v.e_a));
            check($sformatf("v%0d_rf_wdata", idx), rf_wdata, v.e_d);
        end
    endtask

    initial begin
        //              ex_we a   data      lv a   data       rdy pend          we a   data
        // lone load bypass
        tbl[0]  = mk(0, 0,  0,         1, 5,  32'hDEADBEEF, 1, 32'h0,      1, 5,  32'hDEADBEEF);
        tbl[1]  = mk(0, 0,  0,         0, 0,  0,            1, 32'h0,      0, 0,  0);
        // collision: EX wins, load queued then drained
        tbl[2]  = mk(1, 3,  1,         1, 7,  2,            1, 32'h0,      1, 3,  1);
        tbl[3]  = mk(0, 0,  0,         0, 0,  0,            1, 32'h80,     1, 7,  2);
        tbl[4]  = mk(0, 0,  0,         0, 0,  0,            1, 32'h0,      0, 0,  0);
        // full FIFO under sustained EX, then in-order drain
        tbl[5]  = mk(1, 1,  32'h10,    1, 8,  32'h80,       1, 32'h0,      1, 1,  32'h10);
        tbl[6]  = mk(1, 1,  32'h11,    1, 9,  32'h90,       1, 32'h100,    1, 1,  32'h11);
        tbl[7]  = mk(1, 1,  32'h12,    1, 10, 32'hA0,       0, 32'h300,    1, 1,  32'h12);
        tbl[8]  = mk(0, 0,  0,         1, 10, 32'hA0,       0, 32'h300,    1, 8,  32'h80);
        tbl[9]  = mk(0, 0,  0,         1, 10, 32'hA0,       1, 32'h200,    1, 9,  32'h90);
        tbl[10] = mk(0, 0,  0,         0, 0,  0,            1, 32'h400,    1, 10, 32'hA0);
        // cancel: queued r4 killed by younger EX r4
        tbl[11] = mk(1, 2,  5,         1, 4,  32'hAA,       1, 32'h0,      1, 2,  5);
        tbl[12] = mk(1, 4,  32'hBB,    0, 0,  0,            1, 32'h0,      1, 4,  32'hBB);
        tbl[13] = mk(0, 0,  0,         0, 0,  0,            1, 32'h0,      0, 0,  0);
        // x0 handling
        tbl[14] = mk(0, 0,  0,         1, 0,  32'h55,       1, 32'h0,      0, 0,  0);
        tbl[15] = mk(1, 0,  32'h77,    1, 6,  32'h66,       1, 32'h0,      1, 6,  32'h66);
        // queue two loads before a mid-run reset
        tbl[16] = mk(1, 1,  1,         1, 11, 32'h11,       1, 32'h0,      1, 1,  1);
        tbl[17] = mk(1, 1,  2,         1, 12, 32'h12,       1, 32'h800,    1, 1,  2);
        // after reset: fill, stall three cycles, drain
        tbl[18] = mk(1, 1,  3,         1, 13, 32'h13,       1, 32'h0,      1, 1,  3);
        tbl[19] = mk(1, 1,  4,         1, 14, 32'h14,       1, 32'h2000,   1, 1,  4);
        tbl[20] = mk(1, 1,  5,         1, 15, 32'h15,       0, 32'h6000,   1, 1,  5);
        tbl[21] = mk(1, 1,  5,         1, 15, 32'h15,       0, 32'h6000,   1, 1,  5);
        tbl[22] = mk(1, 1,  5,         1, 15, 32'h15,       0, 32'h6000,   1, 1,  5);
        tbl[23] = mk(0, 0,  0,         0, 0,  0,            0, 32'h6000,   1, 13, 32'h13);
        tbl[24] = mk(0, 0,  0,         0, 0,  0,            1, 32'h4000,   1, 14, 32'h14);

        // Initial reset
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rf_we", 32'(rf_we), 32'h0);
        check("reset_rf_waddr", 32'(rf_waddr), 32'h0);
        check("reset_rf_wdata", rf_wdata, 32'h0);
        check("reset_pending", pending, 32'h0);
        check("reset_ready", 32'(lsu_ready), 32'h0);
        check("reset_stall", 32'(stall_cnt), 32'h0);
        rst = 1'b0;

        for (int i = 0; i <= 17; i++) begin
            step(i);
        end

        // Mid-run reset with two loads queued (r11, r12)
        rst = 1'b1;
        drive_idle();
        #1;
        check("midrst_ready_pre", 32'(lsu_ready), 32'h0);
        check("midrst_pending_pre", pending, 32'h1800);
        @(posedge clk);
        #1;
        check("midrst_rf_we", 32'(rf_we), 32'h0);
        check("midrst_pending", pending, 32'h0);
        check("midrst_ready", 32'(lsu_ready), 32'h0);
        check("midrst_stall", 32'(stall_cnt), 32'h0);
        rst = 1'b0;
        #1;
        check("postrst_ready", 32'(lsu_ready), 32'h1);
        check("postrst_pending", pending, 32'h0);
        @(posedge clk);
        #1;
        check("postrst_rf_we", 32'(rf_we), 32'h0);

        for (int i = 18; i <= 22; i++) begin
            step(i);
        end
        check("stall_cnt", 32'(stall_cnt), 32'(c_exp_stall));
        for (int i = 23; i < NV; i++) begin
            step(i);
        end

        drive_idle();
        #1;
        check("final_pending", pending, 32'h0);
        @(posedge clk);
        #1;
        check("final_rf_we", 32'(rf_we), 32'h0);
        check("final_stall", 32'(stall_cnt), 32'(c_exp_stall));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ibex_rf_wb_merge.md
# ibex_rf_wb_merge

Write-back merge stage sitting directly upstream of the FPGA register file's single write port (W1). It merges the single-cycle execute write-back and the variable-latency load write-back into one registered write stream. Load results that collide with an execute write are held in a small in-order FIFO. A per-register pending mask lets decode stall on read-after-write hazards against queued loads.

## Interface
- DataWidth, 32: write data width.
- NumRegs, 32: architectural registers; ADDR_WIDTH = $clog2(NumRegs).
- FifoDepth, 2: load-write holding entries (1..4).

- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ex_we_i  in  1  execute write request; always accepted, no ready.
- ex_waddr_i  in  ADDR_WIDTH  execute destination.
- ex_wdata_i  in  DataWidth  execute result.
- lsu_valid_i  in  1  load write request valid.
- lsu_ready_o  out  1  load write accepted when valid and ready.
- lsu_waddr_i  in  ADDR_WIDTH  load destination.
- lsu_wdata_i  in  DataWidth  load data.
- rf_we_o  out  1  register-file write enable (to W1).
- rf_waddr_o  out  ADDR_WIDTH  register-file write address.
- rf_wdata_o  out  DataWidth  register-file write data.
- pending_o  out  NumRegs  bit i set while a queued load targets register i.
- stall_cnt_o  out  16  load back-pressure cycle count (see Configuration).

## Operation
- Per-cycle selection, in priority order:
  - EX write (ex_we_i=1, ex_waddr_i!=0).
  - FIFO head (pop).
  - Accepted LSU write with an empty FIFO (direct bypass, no push).
- An accepted LSU write is pushed to the FIFO when it is not selected. Push and pop in the same cycle are legal.
- lsu_ready_o = (count < FifoDepth) and not rst_i. It is combinational from the FIFO count only; it never depends on ex_we_i.
- Writes to address 0 are dropped. An EX write to x0 does not take priority. An LSU write to x0 is accepted (handshake completes) but is neither queued nor issued.
- Ordering contract: an EX write is program-order younger than any queued load. A valid FIFO entry whose address equals an issued EX write address is invalidated in that cycle: it never reaches rf_we_o and clears its pending bit. An invalidated head is discarded without consuming a write slot. The next valid entry may issue in that cycle if EX is idle.
- pending_o is combinational from valid FIFO entries. It does not include a same-cycle incoming push.
- FIFO is strictly in-order; entries are never reordered.
- Reset state:
  - FIFO empty; all entries invalid.
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
  - pending_o=0, stall_cnt_o=0, lsu_ready_o=0.

## Timing
- The rf_* outputs are registered: the write selected in cycle N appears on rf_* in cycle N+1. The register file commits it at the edge ending N+1.
- EX latency is fixed at 1 cycle. LSU latency is 1 cycle when bypassed, otherwise 1 + cycles spent queued.
- Sustained EX writes every cycle starve the FIFO. After FifoDepth queued loads, lsu_ready_o drops until EX idles.
- rst_i asserted mid-operation discards all queued writes. rf_we_o is 0 in the cycle after the reset edge.

## Configuration
- IBEX_RF_WB_STATS_EN defined: stall_cnt_o is a 16-bit saturating counter (holds at 16'hFFFF). It increments each cycle with lsu_valid_i=1 and lsu_ready_o=0, and clears on rst_i.
- IBEX_RF_WB_STATS_EN undefined: stall_cnt_o tied to 0 and no counter logic is inferred. The port exists in both builds.

## Test plan
- Lone load: lsu_valid_i=1, waddr=5, wdata=32'hDEADBEEF, EX idle -> next cycle rf_we_o=1, waddr=5, wdata=32'hDEADBEEF; pending_o stays 0.
- Collision: same cycle EX (waddr=3, wdata=1) and LSU (waddr=7, wdata=2) -> cycle+1 writes r3=1 with pending_o[7]=1; cycle+2 writes r7=2, pending_o=0.
- Full FIFO: EX writes r1 every cycle while LSU offers r8, r9, r10 -> r8 and r9 accepted, lsu_ready_o=0 for r10. When EX stops, r8, r9, r10 issue on consecutive cycles in order.
- Cancel: queued LSU r4=0xAA, then EX writes r4=0xBB -> only r4=0xBB is written; pending_o[4] clears the cycle the EX write is selected; 0xAA never appears on rf_*.
- x0 and reset: LSU write to x0 -> handshake completes, no rf_we_o. Assert rst_i with 2 entries queued -> next cycle rf_we_o=0, pending_o=0, lsu_ready_o=0, FIFO empty.
- Stats: with IBEX_RF_WB_STATS_EN, hold LSU stalled 3 cycles -> stall_cnt_o=3. Without the macro -> stall_cnt_o stays 0.
